// File: rtl/prach_pkg.sv
// Shared types and geometry for the PRACH TDM transmit path.
package prach_pkg;
   localparam int NUM_CC      = 3;
   localparam int NUM_ANT     = 8;
   localparam int SLOT_STRIDE = 16;
   localparam int CHN_W       = 8;
   localparam int SS_W        = $clog2(SLOT_STRIDE);
   localparam int CC_W        = $clog2(NUM_CC);
   localparam int ANT_W       = $clog2(NUM_ANT);

   typedef struct packed {
      logic signed [15:0] dr;
      logic signed [15:0] di;
   } iq_t;

   typedef iq_t [NUM_CC-1:0][NUM_ANT-1:0] iq_bank_t;

   typedef enum logic {IDLE, SHIFT} tdm_state_e;
endpackage

// File: rtl/prach_tdm_tx_dbuf.sv
// Two-bank sample-set buffer: one bank is shifted out while the other waits.
// Frame-end release happens before the write, so a set arriving then is never dropped.
module prach_tdm_tx_dbuf
   import prach_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  iq_bank_t         wr_data,
   input  logic             frame_done,
   input  logic [CC_W-1:0]  rd_cc,
   input  logic [ANT_W-1:0] rd_ant,
   output iq_t              rd_iq,
   output logic             act_valid,
   output logic             act_valid_next,
   output logic             ovf
);

   iq_bank_t   bank_q [2];
   iq_bank_t   bank_d [2];
   logic [1:0] valid_q, valid_d;
   logic       sel_q, sel_d;
   logic       ovf_q, ovf_d;

   // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
   always_comb begin
      valid_d = valid_q;
      sel_d   = sel_q;
      bank_d  = bank_q;
      ovf_d   = 1'b0;
      if (frame_done) begin
         valid_d[sel_q] = 1'b0;
         if (valid_q[~sel_q]) sel_d = ~sel_q;
      end
      if (wr_en) begin
         if (!valid_d[sel_d]) begin
            valid_d[sel_d] = 1'b1;
            bank_d[sel_d]  = wr_data;
         end else if (!valid_d[~sel_d]) begin
            valid_d[~sel_d] = 1'b1;
            bank_d[~sel_d]  = wr_data;
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         sel_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         sel_q   <= sel_d;
         ovf_q   <= ovf_d;
      end
   end

   // NOTE: sample storage has no reset; the valid flags alone decide whether a bank is ever read.
   always_ff @(posedge clk) begin
      bank_q <= bank_d;
   end

   assign rd_iq          = bank_q[sel_q][rd_cc][rd_ant];
   assign act_valid      = valid_q[sel_q];
   assign act_valid_next = valid_d[sel_d];
   assign ovf            = ovf_q;

endmodule

// File: rtl/prach_tdm_tx.sv
// PRACH TDM transmitter: serializes captured IQ sets onto the 16-bit dq/dv/chn/sync bus.
// Define PRACH_TDM_TX_SKIP_EMPTY_EN to skip channel slots that carry no antenna.
module prach_tdm_tx
   import prach_pkg::*;
(
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [NUM_CC-1:0][NUM_ANT-1:0][15:0]  din_dr,
   input  logic [NUM_CC-1:0][NUM_ANT-1:0][15:0]  din_di,
   input  logic                                  din_dv,
   input  logic                                  sync_in,
   output logic [15:0]                           dout_dq,
   output logic                                  dout_dv,
   output logic [CHN_W-1:0]                      dout_chn,
   output logic                                  sync_out,
   output logic                                  ovf
);

`ifdef PRACH_TDM_TX_SKIP_EMPTY_EN
   localparam logic [CHN_W-1:0] LAST_SLOT = CHN_W'((NUM_CC-1)*SLOT_STRIDE + NUM_ANT - 1);
`else
   localparam logic [CHN_W-1:0] LAST_SLOT = CHN_W'(NUM_CC*SLOT_STRIDE - 1);
`endif

   tdm_state_e       state_q, state_d;
   logic [CHN_W-1:0] slot_q, slot_d, slot_nxt;
   logic             phase_q, phase_d;
   logic             sync_pend_q, sync_pend_d;
   logic [15:0]      dq_q, dq_d;
   logic             dv_q, dv_d;
   logic [CHN_W-1:0] chn_q, chn_d;
   logic             sync_out_q, sync_out_d;

   iq_bank_t wr_data;
   iq_t      rd_iq;
   logic     act_valid, act_valid_next, frame_done, beat_vld;

   always_comb begin
      wr_data = '0;
      for (int c = 0; c < NUM_CC; c++) begin
         for (int a = 0; a < NUM_ANT; a++) begin
            wr_data[c][a].dr = din_dr[c][a];
            wr_data[c][a].di = din_di[c][a];
         end
      end
   end

   assign frame_done = (state_q == SHIFT) && phase_q && (slot_q == LAST_SLOT);
   assign beat_vld   = (state_q == SHIFT) && (int'(slot_q[SS_W-1:0]) < NUM_ANT);

   prach_tdm_tx_dbuf u_dbuf (
      .clk            (clk),
      .rst_n          (rst_n),
      .wr_en          (din_dv),
      .wr_data        (wr_data),
      .frame_done     (frame_done),
      .rd_cc          (slot_q[SS_W +: CC_W]),
      .rd_ant         (slot_q[ANT_W-1:0]),
      .rd_iq          (rd_iq),
      .act_valid      (act_valid),
      .act_valid_next (act_valid_next),
      .ovf            (ovf)
   );

   // Empty slots are jumped over at the last antenna of each carrier when skipping is enabled.
   always_comb begin
`ifdef PRACH_TDM_TX_SKIP_EMPTY_EN
      if (slot_q[SS_W-1:0] == SS_W'(NUM_ANT - 1))
         slot_nxt = slot_q + CHN_W'(SLOT_STRIDE - NUM_ANT + 1);
      else
         slot_nxt = slot_q + CHN_W'(1);
`else
      slot_nxt = slot_q + CHN_W'(1);
`endif
   end

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      phase_d     = phase_q;
      sync_pend_d = sync_pend_q | sync_in;
      dq_d        = '0;
      dv_d        = 1'b0;
      chn_d       = '0;
      sync_out_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (act_valid) begin
               state_d = SHIFT;
               slot_d  = '0;
               phase_d = 1'b0;
            end
         end
         SHIFT: begin
            chn_d = slot_q;
            dv_d  = beat_vld;
            if (beat_vld) dq_d = phase_q ? rd_iq.di : rd_iq.dr;
            if (slot_q == '0 && !phase_q) begin
               sync_out_d  = sync_pend_q | sync_in;
               sync_pend_d = 1'b0;
            end
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               if (frame_done) begin
                  slot_d = '0;
                  if (!act_valid_next) state_d = IDLE;
               end else begin
                  slot_d = slot_nxt;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         slot_q      <= '0;
         phase_q     <= 1'b0;
         sync_pend_q <= 1'b0;
         dq_q        <= '0;
         dv_q        <= 1'b0;
         chn_q       <= '0;
         sync_out_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         phase_q     <= phase_d;
         sync_pend_q <= sync_pend_d;
         dq_q        <= dq_d;
         dv_q        <= dv_d;
         chn_q       <= chn_d;
         sync_out_q  <= sync_out_d;
      end
   end

   assign dout_dq  = dq_q;
   assign dout_dv  = dv_q;
   assign dout_chn = chn_q;
   assign sync_out = sync_out_q;

endmodule

// File: tb/tb_prach_tdm_tx.sv
// Self-checking bench for prach_tdm_tx against a frame-level reference model.
module tb_prach_tdm_tx;
   import prach_pkg::*;

`ifdef PRACH_TDM_TX_SKIP_EMPTY_EN
   localparam int FB = 2*NUM_CC*NUM_ANT;
`else
   localparam int FB = 2*NUM_CC*SLOT_STRIDE;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic [NUM_CC-1:0][NUM_ANT-1:0][15:0] din_dr, din_di;
   logic din_dv, sync_in;
   logic [15:0] dout_dq;
   logic dout_dv;
   logic [CHN_W-1:0] dout_chn;
   logic sync_out, ovf;

   int n_assert = 0;
   int n_fail   = 0;
   int n_ovf    = 0;
   int n_sync   = 0;

   // reference model state
   bit m_busy, m_act_ok, m_pnd_ok, m_sp;
   int m_k;
   logic [NUM_CC-1:0][NUM_ANT-1:0][15:0] m_act_r, m_act_i, m_pnd_r, m_pnd_i;
   logic [15:0] e_dq;
   logic e_dv, e_sync, e_ovf;
   logic [CHN_W-1:0] e_chn;

   always #5 clk = ~clk;

   prach_tdm_tx dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .din_dr   (din_dr),
      .din_di   (din_di),
      .din_dv   (din_dv),
      .sync_in  (sync_in),
      .dout_dq  (dout_dq),
      .dout_dv  (dout_dv),
      .dout_chn (dout_chn),
      .sync_out (sync_out),
      .ovf      (ovf)
   );

   function automatic int slot_of(input int k);
      int b;
      b = k / 2;
`ifdef PRACH_TDM_TX_SKIP_EMPTY_EN
      return (b / NUM_ANT) * SLOT_STRIDE + (b % NUM_ANT);
`else
      return b;
`endif
   endfunction

   task automatic model_reset();
      m_busy = 0; m_act_ok = 0; m_pnd_ok = 0; m_sp = 0; m_k = 0;
      e_dq = '0; e_dv = 0; e_chn = '0; e_sync = 0; e_ovf = 0;
   endtask

   task automatic model_step();
      int  slot, cc, an;
      bit  end_f, start;
      e_dq = '0; e_dv = 0; e_chn = '0; e_sync = 0; e_ovf = 0;
      if (m_busy) begin
         slot  = slot_of(m_k);
         cc    = slot / SLOT_STRIDE;
         an    = slot % SLOT_STRIDE;
         e_chn = CHN_W'(slot);
         if (an < NUM_ANT) begin
            e_dv = 1;
            e_dq = (m_k % 2 == 1) ? m_act_i[cc][an] : m_act_r[cc][an];
         end
         if (m_k == 0) e_sync = m_sp | sync_in;
      end
      if (m_busy && m_k == 0) m_sp = 0;
      else m_sp = m_sp | sync_in;
      end_f = m_busy && (m_k == FB-1);
      start = !m_busy && m_act_ok;
      if (end_f) begin
         m_act_ok = 0;
         if (m_pnd_ok) begin
            m_act_r = m_pnd_r; m_act_i = m_pnd_i;
            m_act_ok = 1; m_pnd_ok = 0;
         end
      end
      if (din_dv) begin
         if (!m_act_ok) begin
            m_act_r = din_dr; m_act_i = din_di; m_act_ok = 1;
         end else if (!m_pnd_ok) begin
            m_pnd_r = din_dr; m_pnd_i = din_di; m_pnd_ok = 1;
         end else begin
            e_ovf = 1;
         end
      end
      if (end_f) begin
         m_busy = m_act_ok; m_k = 0;
      end else if (m_busy) begin
         m_k++;
      end else if (start) begin
         m_busy = 1; m_k = 0;
      end
   endtask

   task automatic check_outs(input string tag);
      n_assert++;
      assert (dout_dq === e_dq) else begin
         n_fail++; $error("FAIL %s dq: got %h exp %h", tag, dout_dq, e_dq);
      end
      n_assert++;
      assert (dout_dv === e_dv) else begin
         n_fail++; $error("FAIL %s dv: got %b exp %b", tag, dout_dv, e_dv);
      end
      n_assert++;
      assert (dout_chn === e_chn) else begin
         n_fail++; $error("FAIL %s chn: got %0d exp %0d", tag, dout_chn, e_chn);
      end
      n_assert++;
      assert (sync_out === e_sync) else begin
         n_fail++; $error("FAIL %s sync_out: got %b exp %b", tag, sync_out, e_sync);
      end
      n_assert++;
      assert (ovf === e_ovf) else begin
         n_fail++; $error("FAIL %s ovf: got %b exp %b", tag, ovf, e_ovf);
      end
   endtask

   task automatic tick(input bit dv, input bit sy, input string tag);
      din_dv  = dv;
      sync_in = sy;
      @(posedge clk);
      model_step();
      #1;
      check_outs(tag);
      if (ovf === 1'b1) n_ovf++;
      if (sync_out === 1'b1) n_sync++;
      din_dv  = 0;
      sync_in = 0;
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) tick(0, 0, tag);
   endtask

   task automatic load_rand();
      for (int c = 0; c < NUM_CC; c++)
         for (int a = 0; a < NUM_ANT; a++) begin
            din_dr[c][a] = 16'($urandom);
            din_di[c][a] = 16'($urandom);
         end
   endtask

   task automatic do_reset(input int cycles, input string tag);
      #2;
      rst_n = 0;
      #1;
      model_reset();
      check_outs(tag);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         check_outs(tag);
      end
      rst_n = 1;
   endtask

   initial begin
      rst_n = 0; din_dv = 0; sync_in = 0; din_dr = '0; din_di = '0;
      model_reset();
      #1;
      check_outs("reset");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_outs("reset");
      end
      rst_n = 1;
      run(3, "idle");

      // single frame with the positional pattern
      for (int c = 0; c < NUM_CC; c++)
         for (int a = 0; a < NUM_ANT; a++) begin
            din_dr[c][a] = 16'(c*256 + a);
            din_di[c][a] = ~din_dr[c][a];
         end
      tick(1, 0, "t1_load");
      run(FB + 8, "t1_frame");

      // periodic sets give back-to-back frames
      n_ovf = 0;
      for (int f = 0; f < 4; f++) begin
         load_rand();
         tick(1, 0, "t2_load");
         run(FB - 1, "t2_frame");
      end
      run(FB + 4, "t2_tail");
      n_assert++;
      assert (n_ovf == 0) else begin
         n_fail++; $error("FAIL t2_no_ovf: got %0d exp 0", n_ovf);
      end

      // three sets within one frame: the third is dropped
      n_ovf = 0;
      load_rand(); tick(1, 0, "t3_a");
      run(9, "t3");
      load_rand(); tick(1, 0, "t3_b");
      run(9, "t3");
      load_rand(); tick(1, 0, "t3_c");
      run(2*FB + 10, "t3_frames");
      n_assert++;
      assert (n_ovf == 1) else begin
         n_fail++; $error("FAIL t3_ovf_count: got %0d exp 1", n_ovf);
      end

      // sync mid-frame, then the same-cycle case
      n_sync = 0;
      load_rand(); tick(1, 0, "t4_a");
      run(30, "t4");
      tick(0, 1, "t4_sync");
      run(9, "t4");
      load_rand(); tick(1, 0, "t4_b");
      run(2*FB + 10, "t4_frames");
      load_rand(); tick(1, 0, "t4_c");
      tick(0, 0, "t4_c");
      tick(0, 1, "t4_same_cycle");
      run(FB + 4, "t4_tail");
      n_assert++;
      assert (n_sync == 2) else begin
         n_fail++; $error("FAIL t4_sync_count: got %0d exp 2", n_sync);
      end

      // reset in the middle of a frame, then a clean restart
      load_rand(); tick(1, 0, "t5_a");
      run(41, "t5_pre");
      do_reset(3, "t5_reset");
      run(2, "t5_idle");
      load_rand(); tick(1, 0, "t5_b");
      run(FB + 6, "t5_frame");

      // random traffic
      for (int i = 0; i < 600; i++) begin
         load_rand();
         tick($urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0, "rand");
      end
      run(2*FB + 6, "rand_tail");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
